// File: rtl/mc_sched_pkg.sv
// Shared types for the bank read/write scheduler.
package mc_sched_pkg;

  localparam int RA_BITS_DEF = 10;

  typedef enum logic [1:0] {RD, WR, TURN} sched_state_t;
  typedef logic [RA_BITS_DEF-1:0] row_t;

endpackage

// File: rtl/sched_sat_counter.sv
// Saturating up-counter with synchronous clear; stops at LIMIT.
module sched_sat_counter #(
  parameter int WIDTH = 5,
  parameter int LIMIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             sat_o
);

  logic [WIDTH-1:0] cnt_q;

  assign cnt_o = cnt_q;
  assign sat_o = (cnt_q == WIDTH'(LIMIT));

  always_ff @(posedge clk) begin
    if (rst || clr_i)         cnt_q <= '0;
    else if (inc_i && !sat_o) cnt_q <= cnt_q + WIDTH'(1);
  end

endmodule

// File: rtl/bank_rw_scheduler.sv
// Pops one bank's read/write FIFOs, batching direction changes with a
// turnaround gap, and issues tagged requests through one output register.
module bank_rw_scheduler
  import mc_sched_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int RA_POS       = 20,
  parameter int RA_BITS      = RA_BITS_DEF,
  parameter int WR_BURST     = 8,
  parameter int STARVE_LIMIT = 16,
  parameter int TURNAROUND   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  input  logic                  rd_valid_i,
  input  logic                  rd_mid_i,
  output logic                  rd_grant_o,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  wr_valid_i,
  input  logic                  wr_mid_i,
  output logic                  wr_grant_o,
  output logic [DATA_WIDTH-1:0] req_data_o,
  output logic                  req_valid_o,
  output logic                  req_is_wr_o,
  output logic                  req_row_hit_o,
  input  logic                  req_ready_i
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = $clog2(WR_BURST + 1);
  localparam int TW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
  localparam logic [BW-1:0] HALF_BURST = BW'(WR_BURST / 2);

  sched_state_t state_q, state_d, tgt_q, tgt_d;
  logic [TW-1:0] turn_q, turn_d;

  logic [SW-1:0] starve_cnt;
  logic          starve_sat, starve_inc, starve_clr;
  logic [BW-1:0] burst_cnt;
  logic          burst_sat, burst_inc, burst_clr;

  logic                  load_en, exit_rd, exit_wr, rd_g, wr_g, load;
  logic [DATA_WIDTH-1:0] popped;
  logic [RA_BITS-1:0]    popped_row, open_row_q;
  logic                  row_valid_q;

  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q, is_wr_q, hit_q;

  sched_sat_counter #(.WIDTH(SW), .LIMIT(STARVE_LIMIT)) u_starve (
    .clk(clk), .rst(rst), .clr_i(starve_clr), .inc_i(starve_inc),
    .cnt_o(starve_cnt), .sat_o(starve_sat)
  );

  sched_sat_counter #(.WIDTH(BW), .LIMIT(WR_BURST)) u_burst (
    .clk(clk), .rst(rst), .clr_i(burst_clr), .inc_i(burst_inc),
    .cnt_o(burst_cnt), .sat_o(burst_sat)
  );

  assign load_en = !valid_q || req_ready_i;
  assign exit_rd = wr_valid_i &&
                   (wr_mid_i || !rd_valid_i || starve_cnt == SW'(STARVE_LIMIT));
  assign exit_wr = rd_valid_i &&
                   (!wr_valid_i || (burst_sat && !wr_mid_i) ||
                    (rd_mid_i && !wr_mid_i && burst_cnt >= HALF_BURST));

  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    turn_d     = turn_q;
    rd_g       = 1'b0;
    wr_g       = 1'b0;
    starve_inc = 1'b0;
    starve_clr = 1'b0;
    burst_inc  = 1'b0;
    burst_clr  = 1'b0;
    case (state_q)
      RD: begin
        rd_g = load_en && rd_valid_i && !exit_rd;
        if (exit_rd) begin
          state_d = TURN;
          tgt_d   = WR;
          turn_d  = TW'(TURNAROUND - 1);
        end else begin
          starve_inc = wr_valid_i && !starve_sat;
        end
      end
      WR: begin
        wr_g      = load_en && wr_valid_i && !exit_wr;
        burst_inc = wr_g;
        if (exit_wr) begin
          state_d = TURN;
          tgt_d   = RD;
          turn_d  = TW'(TURNAROUND - 1);
        end
      end
      TURN: begin
        if (turn_q == '0) begin
          state_d = tgt_q;
          // Both counters restart on every write-mode entry.
          if (tgt_q == WR) begin
            starve_clr = 1'b1;
            burst_clr  = 1'b1;
          end
        end else begin
          turn_d = turn_q - TW'(1);
        end
      end
      default: state_d = RD;
    endcase
    if (rst) begin
      rd_g = 1'b0;
      wr_g = 1'b0;
    end
  end

  assign load       = rd_g || wr_g;
  assign popped     = wr_g ? wr_data_i : rd_data_i;
  assign popped_row = popped[RA_POS +: RA_BITS];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RD;
      tgt_q       <= RD;
      turn_q      <= '0;
      open_row_q  <= '0;
      row_valid_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      is_wr_q     <= 1'b0;
      hit_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      turn_q  <= turn_d;
      if (load) begin
        data_q      <= popped;
        valid_q     <= 1'b1;
        is_wr_q     <= wr_g;
        hit_q       <= row_valid_q && (popped_row == open_row_q);
        open_row_q  <= popped_row;
        row_valid_q <= 1'b1;
      end else if (req_ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rd_grant_o    = rd_g;
  assign wr_grant_o    = wr_g;
  assign req_data_o    = data_q;
  assign req_valid_o   = valid_q;
  assign req_is_wr_o   = is_wr_q;
  assign req_row_hit_o = hit_q;

endmodule
